// File: rtl/ahb2_arbiter_if.sv
// ahb2_arbiter_if -- shared AHB2 arbitration signals.
//   slave  modport: arbiter view (requests/bus status in, grant/owner out)
//   master modport: bus/master view (requests/bus status out, grant/owner in)
// Signals:
//   hbusreq[NUM_MST]  per-master bus request
//   hlock[NUM_MST]    per-master lock request (only with AHB2_ARB_LOCK_EN)
//   htrans[2]         shared transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hburst[3]         shared burst type
//   hready            shared transfer-done
//   hgrant[NUM_MST]   one-hot grant
//   hmaster[MW]       address-phase owner index
//   hmastlock         address phase is locked
// Optional feature macro: AHB2_ARB_LOCK_EN
interface ahb2_arbiter_if #(
   parameter int NUM_MST = 4
);
   localparam int MW = $clog2(NUM_MST);

   logic [NUM_MST-1:0] hbusreq;
`ifdef AHB2_ARB_LOCK_EN
   logic [NUM_MST-1:0] hlock;
`endif
   logic [1:0]         htrans;
   logic [2:0]         hburst;
   logic               hready;
   logic [NUM_MST-1:0] hgrant;
   logic [MW-1:0]      hmaster;
   logic               hmastlock;

   modport slave (
`ifdef AHB2_ARB_LOCK_EN
      input  hlock,
`endif
      input  hbusreq, htrans, hburst, hready,
      output hgrant, hmaster, hmastlock
   );

   modport master (
`ifdef AHB2_ARB_LOCK_EN
      output hlock,
`endif
      output hbusreq, htrans, hburst, hready,
      input  hgrant, hmaster, hmastlock
   );
endinterface

// File: rtl/ahb2_arbiter.sv
// ahb2_arbiter -- round-robin AHB2 bus arbiter with burst-aware hand-over.
// Ports:
//   hclk      bus clock, all state updates on the rising edge
//   hreset_n  synchronous active-low reset
//   bus       ahb2_arbiter_if.slave (hbusreq, [hlock], htrans, hburst,
//             hready in; hgrant, hmaster, hmastlock out, all registered)
// Parameters: NUM_MST (2..8) masters, DEF_MST park master index.
// Optional feature macro: AHB2_ARB_LOCK_EN (hlock input, lock hold,
// registered hmastlock). Without it hmastlock is constant 0.
module ahb2_arbiter #(
   parameter int NUM_MST = 4,
   parameter int DEF_MST = 0
) (
   input  logic           hclk,
   input  logic           hreset_n,
   ahb2_arbiter_if.slave  bus
);
   localparam int MW = $clog2(NUM_MST);

   localparam logic [1:0] HT_IDLE   = 2'd0;
   localparam logic [1:0] HT_BUSY   = 2'd1;
   localparam logic [1:0] HT_NONSEQ = 2'd2;
   localparam logic [1:0] HT_SEQ    = 2'd3;

   localparam logic [MW-1:0] DEF_IDX = MW'(DEF_MST);

   logic [NUM_MST-1:0] hgrant_q,    hgrant_d;
   logic [MW-1:0]      gnt_idx_q,   gnt_idx_d;
   logic [MW-1:0]      hmaster_q,   hmaster_d;
   logic               hmastlock_q, hmastlock_d;
   logic [3:0]         cnt_q,       cnt_d;
   logic [MW-1:0]      ptr_q,       ptr_d;

   logic               lock_hold;
   logic               arb_pt;
   logic               any_req;
   logic [MW-1:0]      win_idx;
   logic [MW-1:0]      cand;

   // Remaining SEQ beats after the NONSEQ of a fixed-length burst.
   function automatic logic [3:0] burst_beats(input logic [2:0] hb);
      case (hb)
         3'd2, 3'd3: burst_beats = 4'd3;
         3'd4, 3'd5: burst_beats = 4'd7;
         3'd6, 3'd7: burst_beats = 4'd15;
         default:    burst_beats = 4'd0;
      endcase
   endfunction

`ifdef AHB2_ARB_LOCK_EN
   assign lock_hold = bus.hlock[gnt_idx_q];
`else
   assign lock_hold = 1'b0;
`endif

   always_comb begin
      cnt_d = cnt_q;
      if (bus.hready) begin
         case (bus.htrans)
            HT_IDLE:   cnt_d = 4'd0;
            HT_BUSY:   cnt_d = cnt_q;
            HT_NONSEQ: cnt_d = burst_beats(bus.hburst);
            HT_SEQ:    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
            default:   cnt_d = cnt_q;
         endcase
      end
   end

   // Walk downwards so the candidate nearest to ptr+1 is assigned last and wins.
   always_comb begin
      any_req = 1'b0;
      win_idx = ptr_q;
      cand    = ptr_q;
      for (int i = NUM_MST; i >= 1; i--) begin
         cand = MW'((int'(ptr_q) + i) % NUM_MST);
         if (bus.hbusreq[cand]) begin
            any_req = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      gnt_idx_d = gnt_idx_q;
      ptr_d     = ptr_q;
      arb_pt    = bus.hready && (cnt_d == 4'd0) && !lock_hold;
      if (arb_pt) begin
         if (any_req) begin
            gnt_idx_d = win_idx;
            ptr_d     = win_idx;
         end else begin
            // Park on the default master; pointer keeps the last real winner.
            gnt_idx_d = DEF_IDX;
         end
      end
      // Grant is always decoded from one index, so it cannot be zero or multi-hot.
      hgrant_d            = '0;
      hgrant_d[gnt_idx_d] = 1'b1;

      hmaster_d = bus.hready ? gnt_idx_q : hmaster_q;
`ifdef AHB2_ARB_LOCK_EN
      hmastlock_d = bus.hready ? bus.hlock[gnt_idx_q] : hmastlock_q;
`else
      hmastlock_d = 1'b0;
`endif
   end

   always_ff @(posedge hclk) begin
      if (!hreset_n) begin
         hgrant_q          <= '0;
         hgrant_q[DEF_IDX] <= 1'b1;
         gnt_idx_q         <= DEF_IDX;
         hmaster_q         <= DEF_IDX;
         hmastlock_q       <= 1'b0;
         cnt_q             <= 4'd0;
         ptr_q             <= DEF_IDX;
      end else begin
         hgrant_q    <= hgrant_d;
         gnt_idx_q   <= gnt_idx_d;
         hmaster_q   <= hmaster_d;
         hmastlock_q <= hmastlock_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.hgrant    = hgrant_q;
   assign bus.hmaster   = hmaster_q;
   assign bus.hmastlock = hmastlock_q;
endmodule

// File: tb/tb_ahb2_arbiter.sv
module tb_ahb2_arbiter;
   logic hclk;
   logic hreset_n;
   int   checks;
   int   errors;

   ahb2_arbiter_if #(.NUM_MST(4)) bus ();

   ahb2_arbiter #(.NUM_MST(4), .DEF_MST(0)) dut (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .bus      (bus)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge hclk);
      #1;
   endtask

   task automatic drive(input logic [3:0] req, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rdy);
      bus.hbusreq = req;
      bus.htrans  = tr;
      bus.hburst  = bu;
      bus.hready  = rdy;
   endtask

   task automatic do_reset;
      hreset_n = 1'b0;
      drive(4'b0000, 2'd0, 3'd0, 1'b1);
`ifdef AHB2_ARB_LOCK_EN
      bus.hlock = 4'b0000;
`endif
      tick;
      tick;
      hreset_n = 1'b1;
   endtask

   task automatic test_reset;
      hreset_n = 1'b0;
      drive(4'b1111, 2'd2, 3'd7, 1'b1);
`ifdef AHB2_ARB_LOCK_EN
      bus.hlock = 4'b1111;
`endif
      tick;
      tick;
      checks++;
      if (bus.hgrant !== 4'b0001) begin
         errors++;
         $display("FAIL reset_hgrant: got %b expected %b", bus.hgrant, 4'b0001);
      end
      checks++;
      if (bus.hmaster !== 2'd0) begin
         errors++;
         $display("FAIL reset_hmaster: got %0d expected 0", bus.hmaster);
      end
      checks++;
      if (bus.hmastlock !== 1'b0) begin
         errors++;
         $display("FAIL reset_hmastlock: got %b expected 0", bus.hmastlock);
      end
      do_reset;
   endtask

   task automatic test_park;
      do_reset;
      drive(4'b0000, 2'd0, 3'd0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick;
         checks++;
         if (bus.hgrant !== 4'b0001 || bus.hmaster !== 2'd0) begin
            errors++;
            $display("FAIL park_cycle%0d: got hgrant=%b hmaster=%0d expected 0001/0",
                     i, bus.hgrant, bus.hmaster);
         end
      end
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_g [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      logic [1:0] exp_m [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset;
      drive(4'b1111, 2'd2, 3'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick;
         checks++;
         if (bus.hgrant !== exp_g[i] || bus.hmaster !== exp_m[i] || bus.hmastlock !== 1'b0) begin
            errors++;
            $display("FAIL rr_step%0d: got hgrant=%b hmaster=%0d lock=%b expected %b/%0d/0",
                     i, bus.hgrant, bus.hmaster, bus.hmastlock, exp_g[i], exp_m[i]);
         end
      end
   endtask

   task automatic test_latency;
      do_reset;
      drive(4'b0100, 2'd0, 3'd0, 1'b0);
      tick;
      checks++;
      if (bus.hgrant !== 4'b0001 || bus.hmaster !== 2'd0) begin
         errors++;
         $display("FAIL latency_hready_low: got hgrant=%b hmaster=%0d expected 0001/0",
                  bus.hgrant, bus.hmaster);
      end
      bus.hready = 1'b1;
      tick;
      checks++;
      if (bus.hgrant !== 4'b0100) begin
         errors++;
         $display("FAIL latency_grant: got %b expected 0100", bus.hgrant);
      end
   endtask

   task automatic test_park_pointer;
      do_reset;
      drive(4'b0100, 2'd0, 3'd0, 1'b1);
      tick;
      checks++;
      if (bus.hgrant !== 4'b0100) begin
         errors++;
         $display("FAIL ptr_setup: got %b expected 0100", bus.hgrant);
      end
      bus.hbusreq = 4'b0000;
      tick;
      checks++;
      if (bus.hgrant !== 4'b0001) begin
         errors++;
         $display("FAIL ptr_park: got %b expected 0001", bus.hgrant);
      end
      bus.hbusreq = 4'b1111;
      tick;
      checks++;
      if (bus.hgrant !== 4'b1000) begin
         errors++;
         $display("FAIL ptr_kept: got %b expected 1000", bus.hgrant);
      end
   endtask

   task automatic test_burst4;
      logic [1:0] tr [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
      logic [3:0] eg [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
      do_reset;
      drive(4'b0010, 2'd0, 3'd0, 1'b1);
      tick;
      checks++;
      if (bus.hgrant !== 4'b0010) begin
         errors++;
         $display("FAIL b4_setup: got %b expected 0010", bus.hgrant);
      end
      for (int i = 0; i < 4; i++) begin
         // Owner drops its request after the NONSEQ; grant must still hold.
         drive((i == 0) ? 4'b0110 : 4'b0100, tr[i], 3'd3, 1'b1);
         tick;
         checks++;
         if (bus.hgrant !== eg[i]) begin
            errors++;
            $display("FAIL b4_beat%0d: got %b expected %b", i, bus.hgrant, eg[i]);
         end
      end
   endtask

   task automatic test_burst8_wait;
      logic [1:0] tr [11] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};
      logic       rd [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [3:0] eg;
      do_reset;
      drive(4'b0010, 2'd0, 3'd0, 1'b1);
      tick;
      drive(4'b0110, 2'd2, 3'd5, 1'b1);
      tick;
      checks++;
      if (bus.hgrant !== 4'b0010) begin
         errors++;
         $display("FAIL b8_nonseq: got %b expected 0010", bus.hgrant);
      end
      for (int i = 0; i < 11; i++) begin
         drive(4'b0100, tr[i], 3'd5, rd[i]);
         tick;
         eg = (i == 10) ? 4'b0100 : 4'b0010;
         checks++;
         if (bus.hgrant !== eg) begin
            errors++;
            $display("FAIL b8_step%0d: got %b expected %b", i, bus.hgrant, eg);
         end
      end
   endtask

   task automatic test_abort16;
      do_reset;
      drive(4'b1001, 2'd2, 3'd7, 1'b1);
      tick;
      for (int i = 0; i < 4; i++) begin
         bus.htrans = 2'd3;
         tick;
      end
      checks++;
      if (bus.hgrant !== 4'b0001) begin
         errors++;
         $display("FAIL b16_in_burst: got %b expected 0001", bus.hgrant);
      end
      drive(4'b1000, 2'd0, 3'd7, 1'b1);
      tick;
      checks++;
      if (bus.hgrant !== 4'b1000) begin
         errors++;
         $display("FAIL b16_idle_abort: got %b expected 1000", bus.hgrant);
      end
   endtask

   task automatic test_reset_mid_burst;
      do_reset;
      drive(4'b0100, 2'd0, 3'd0, 1'b1);
      tick;
      drive(4'b0100, 2'd2, 3'd7, 1'b1);
      tick;
      bus.htrans = 2'd3;
      tick;
      hreset_n = 1'b0;
      tick;
      checks++;
      if (bus.hgrant !== 4'b0001 || bus.hmaster !== 2'd0) begin
         errors++;
         $display("FAIL midrst_state: got hgrant=%b hmaster=%0d expected 0001/0",
                  bus.hgrant, bus.hmaster);
      end
      hreset_n = 1'b1;
      drive(4'b1010, 2'd3, 3'd7, 1'b1);
      tick;
      checks++;
      if (bus.hgrant !== 4'b0010) begin
         errors++;
         $display("FAIL midrst_rearb: got %b expected 0010", bus.hgrant);
      end
   endtask

`ifdef AHB2_ARB_LOCK_EN
   task automatic test_lock;
      do_reset;
      drive(4'b1111, 2'd2, 3'd0, 1'b1);
      bus.hlock = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++;
         if (bus.hgrant !== 4'b0001 || bus.hmastlock !== 1'b1) begin
            errors++;
            $display("FAIL lock_hold%0d: got hgrant=%b hmastlock=%b expected 0001/1",
                     i, bus.hgrant, bus.hmastlock);
         end
      end
      bus.hlock = 4'b0000;
      tick;
      checks++;
      if (bus.hgrant !== 4'b0010 || bus.hmastlock !== 1'b0) begin
         errors++;
         $display("FAIL lock_release: got hgrant=%b hmastlock=%b expected 0010/0",
                  bus.hgrant, bus.hmastlock);
      end
   endtask
`endif

   initial begin
      checks   = 0;
      errors   = 0;
      hreset_n = 1'b0;
      drive(4'b0000, 2'd0, 3'd0, 1'b1);
`ifdef AHB2_ARB_LOCK_EN
      bus.hlock = 4'b0000;
`endif
      test_reset;
      test_park;
      test_round_robin;
      test_latency;
      test_park_pointer;
      test_burst4;
      test_burst8_wait;
      test_abort16;
      test_reset_mid_burst;
`ifdef AHB2_ARB_LOCK_EN
      test_lock;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
